// File: rtl/colocar_barcos.sv
// Ship placement stage: cursor movement, rotation and validated placement of ships 1..N on a 5x5 board.
// Optional VISTA_PREVIA_EN overlays the current ship at the cursor onto vista while placing.
module colocar_barcos (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  cantidadBarcosSeleccionada,
   input  logic        seleccionListo,
   input  logic        btnArriba,
   input  logic        btnAbajo,
   input  logic        btnIzquierda,
   input  logic        btnDerecha,
   input  logic        btnRotar,
   input  logic        btnColocar,
   output logic [24:0] tablero,
   output logic [2:0]  fila,
   output logic [2:0]  columna,
   output logic        orientacion,
   output logic [2:0]  barcosColocados,
   output logic        colocacionLista,
   output logic        errorColocacion,
   output logic [24:0] vista
);

   localparam int unsigned DIM      = 5;
   localparam int unsigned N_CELDAS = DIM * DIM;
   localparam int unsigned POS_W    = 3;
   localparam int unsigned N_BTN    = 6;
   localparam int unsigned MAX_BAR  = 5;

   // Button vector bit positions
   localparam int unsigned B_DER = 0;
   localparam int unsigned B_IZQ = 1;
   localparam int unsigned B_ABA = 2;
   localparam int unsigned B_ARR = 3;
   localparam int unsigned B_ROT = 4;
   localparam int unsigned B_COL = 5;

   typedef enum logic [1:0] {
      ESPERA    = 2'd0,
      COLOCANDO = 2'd1,
      VALIDAR   = 2'd2,
      LISTO     = 2'd3
   } estado_t;

   estado_t             estado_q, estado_d;
   logic [N_CELDAS-1:0] tablero_q, tablero_d;
   logic [POS_W-1:0]    fila_q, fila_d;
   logic [POS_W-1:0]    columna_q, columna_d;
   logic                orient_q, orient_d;
   logic [POS_W-1:0]    barcos_q, barcos_d;
   logic [POS_W-1:0]    cantidad_q, cantidad_d;
   logic                lista_q, lista_d;
   logic                error_q, error_d;
   logic [N_BTN-1:0]    btn_q, btn_d;

   logic [N_BTN-1:0]    btn_c;
   logic [N_BTN-1:0]    flanco_c;
   logic [POS_W-1:0]    largo_c;
   logic [N_CELDAS-1:0] mascara_c;
   logic                encaja_c;
   logic [POS_W-1:0]    barcos_nuevo_c;

   // Cells covered by a ship of length len anchored at (f,c); out-of-board cells are dropped
   function automatic logic [N_CELDAS-1:0] mascara_barco(
      input logic [POS_W-1:0] f,
      input logic [POS_W-1:0] c,
      input logic             o,
      input logic [POS_W-1:0] len
   );
      logic [N_CELDAS-1:0] m;
      int unsigned r;
      int unsigned k;
      m = '0;
      for (int unsigned i = 0; i < DIM; i++) begin
         r = 32'(f) + (o ? i : 32'd0);
         k = 32'(c) + (o ? 32'd0 : i);
         if ((i < 32'(len)) && (r < DIM) && (k < DIM)) begin
            m[5'(r * DIM + k)] = 1'b1;
         end
      end
      return m;
   endfunction

   assign btn_c    = {btnColocar, btnRotar, btnArriba, btnAbajo, btnIzquierda, btnDerecha};
   assign flanco_c = btn_c & ~btn_q;
   assign largo_c  = barcos_q + 3'd1;

   // Placement legality: ship end stays on the board and no cell is already occupied
   always_comb begin
      logic dentro;
      mascara_c = mascara_barco(fila_q, columna_q, orient_q, largo_c);
      if (orient_q) begin
         dentro = (4'(fila_q) + 4'(largo_c)) <= 4'(DIM);
      end else begin
         dentro = (4'(columna_q) + 4'(largo_c)) <= 4'(DIM);
      end
      encaja_c = dentro && ((mascara_c & tablero_q) == '0);
   end

   assign barcos_nuevo_c = barcos_q + 3'd1;

   // Next-state and output logic
   always_comb begin
      estado_d   = estado_q;
      tablero_d  = tablero_q;
      fila_d     = fila_q;
      columna_d  = columna_q;
      orient_d   = orient_q;
      barcos_d   = barcos_q;
      cantidad_d = cantidad_q;
      lista_d    = lista_q;
      error_d    = 1'b0;
      btn_d      = btn_c;

      case (estado_q)
         ESPERA: begin
            if (seleccionListo && (cantidadBarcosSeleccionada != 3'd0) &&
                (cantidadBarcosSeleccionada <= 3'(MAX_BAR))) begin
               cantidad_d = cantidadBarcosSeleccionada;
               estado_d   = COLOCANDO;
            end
         end
         COLOCANDO: begin
            // error is registered here so its pulse lines up with the VALIDAR cycle
            if (flanco_c[B_COL]) begin
               error_d  = ~encaja_c;
               estado_d = VALIDAR;
            end else if (flanco_c[B_ROT]) begin
               orient_d = ~orient_q;
            end else if (flanco_c[B_ARR]) begin
               if (fila_q != 3'd0) fila_d = fila_q - 3'd1;
            end else if (flanco_c[B_ABA]) begin
               if (fila_q != 3'(DIM - 1)) fila_d = fila_q + 3'd1;
            end else if (flanco_c[B_IZQ]) begin
               if (columna_q != 3'd0) columna_d = columna_q - 3'd1;
            end else if (flanco_c[B_DER]) begin
               if (columna_q != 3'(DIM - 1)) columna_d = columna_q + 3'd1;
            end
         end
         VALIDAR: begin
            if (encaja_c) begin
               tablero_d = tablero_q | mascara_c;
               barcos_d  = barcos_nuevo_c;
               fila_d    = 3'd0;
               columna_d = 3'd0;
               orient_d  = 1'b0;
               if (barcos_nuevo_c == cantidad_q) begin
                  estado_d = LISTO;
                  lista_d  = 1'b1;
               end else begin
                  estado_d = COLOCANDO;
               end
            end else begin
               estado_d = COLOCANDO;
            end
         end
         LISTO: begin
            lista_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado_q   <= ESPERA;
         tablero_q  <= '0;
         fila_q     <= '0;
         columna_q  <= '0;
         orient_q   <= 1'b0;
         barcos_q   <= '0;
         cantidad_q <= '0;
         lista_q    <= 1'b0;
         error_q    <= 1'b0;
         btn_q      <= '0;
      end else begin
         estado_q   <= estado_d;
         tablero_q  <= tablero_d;
         fila_q     <= fila_d;
         columna_q  <= columna_d;
         orient_q   <= orient_d;
         barcos_q   <= barcos_d;
         cantidad_q <= cantidad_d;
         lista_q    <= lista_d;
         error_q    <= error_d;
         btn_q      <= btn_d;
      end
   end

`ifdef VISTA_PREVIA_EN
   logic [N_CELDAS-1:0] vista_q, vista_d;

   // Preview is built from next-state values so it stays aligned with the registered cursor
   always_comb begin
      vista_d = tablero_d;
      if (estado_d == COLOCANDO) begin
         vista_d = tablero_d | mascara_barco(fila_d, columna_d, orient_d, barcos_d + 3'd1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vista_q <= '0;
      end else begin
         vista_q <= vista_d;
      end
   end

   assign vista = vista_q;
`else
   assign vista = tablero_q;
`endif

   assign tablero         = tablero_q;
   assign fila            = fila_q;
   assign columna         = columna_q;
   assign orientacion     = orient_q;
   assign barcosColocados = barcos_q;
   assign colocacionLista = lista_q;
   assign errorColocacion = error_q;

endmodule

// File: tb/tb_colocar_barcos.sv
// Scoreboard bench for colocar_barcos: a behavioural board model predicts every cycle's outputs.
module tb_colocar_barcos;

   localparam logic [5:0] B_NONE = 6'b000000;
   localparam logic [5:0] B_DER  = 6'b000001;
   localparam logic [5:0] B_IZQ  = 6'b000010;
   localparam logic [5:0] B_ABA  = 6'b000100;
   localparam logic [5:0] B_ARR  = 6'b001000;
   localparam logic [5:0] B_ROT  = 6'b010000;
   localparam logic [5:0] B_COL  = 6'b100000;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  cantidadBarcosSeleccionada;
   logic        seleccionListo;
   logic        btnArriba, btnAbajo, btnIzquierda, btnDerecha, btnRotar, btnColocar;
   logic [24:0] tablero;
   logic [2:0]  fila, columna;
   logic        orientacion;
   logic [2:0]  barcosColocados;
   logic        colocacionLista;
   logic        errorColocacion;
   logic [24:0] vista;

   always #5 clk = ~clk;

   colocar_barcos dut (
      .clk                        (clk),
      .reset                      (reset),
      .cantidadBarcosSeleccionada (cantidadBarcosSeleccionada),
      .seleccionListo             (seleccionListo),
      .btnArriba                  (btnArriba),
      .btnAbajo                   (btnAbajo),
      .btnIzquierda               (btnIzquierda),
      .btnDerecha                 (btnDerecha),
      .btnRotar                   (btnRotar),
      .btnColocar                 (btnColocar),
      .tablero                    (tablero),
      .fila                       (fila),
      .columna                    (columna),
      .orientacion                (orientacion),
      .barcosColocados            (barcosColocados),
      .colocacionLista            (colocacionLista),
      .errorColocacion            (errorColocacion),
      .vista                      (vista)
   );

   int vectors = 0;
   int miscompares = 0;
   logic [63:0] exp_q[$];
   string       tag_q[$];

   logic        g_sel;
   logic [2:0]  g_cnt;

   // Reference model state (0 espera, 1 colocando, 2 validar, 3 listo)
   int          m_st, m_f, m_c, m_o, m_n, m_cnt, m_lista, m_err;
   logic [24:0] m_tab;
   logic [5:0]  m_prev;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [24:0] m_mask();
      logic [24:0] m;
      int r, k;
      m = '0;
      for (int i = 0; i < m_n + 1; i++) begin
         r = m_f + ((m_o != 0) ? i : 0);
         k = m_c + ((m_o != 0) ? 0 : i);
         if (r < 5 && k < 5) m[5'(r * 5 + k)] = 1'b1;
      end
      return m;
   endfunction

   function automatic bit m_fits();
      int len;
      len = m_n + 1;
      if (m_o != 0) begin
         if (m_f + len > 5) return 1'b0;
      end else begin
         if (m_c + len > 5) return 1'b0;
      end
      return (m_mask() & m_tab) == 25'd0;
   endfunction

   function automatic logic [63:0] m_snap();
      logic [24:0] v;
      v = m_tab;
`ifdef VISTA_PREVIA_EN
      if (m_st == 1) v = m_tab | m_mask();
`endif
      return {2'b00, m_tab, 3'(m_f), 3'(m_c), 1'(m_o), 3'(m_n), 1'(m_lista), 1'(m_err), v};
   endfunction

   function automatic logic [63:0] dut_snap();
      return {2'b00, tablero, fila, columna, orientacion, barcosColocados,
              colocacionLista, errorColocacion, vista};
   endfunction

   task automatic model_reset();
      m_st = 0; m_f = 0; m_c = 0; m_o = 0; m_n = 0; m_cnt = 0;
      m_lista = 0; m_err = 0; m_tab = '0; m_prev = '0;
   endtask

   task automatic model_clock(input logic [5:0] b);
      logic [5:0] e;
      e = b & ~m_prev;
      m_prev = b;
      m_err = 0;
      case (m_st)
         0: if (g_sel && g_cnt >= 3'd1 && g_cnt <= 3'd5) begin
               m_cnt = int'(g_cnt);
               m_st  = 1;
            end
         1: begin
            if (e[5]) begin
               m_err = m_fits() ? 0 : 1;
               m_st  = 2;
            end else if (e[4]) m_o = 1 - m_o;
            else if (e[3]) begin if (m_f > 0) m_f--; end
            else if (e[2]) begin if (m_f < 4) m_f++; end
            else if (e[1]) begin if (m_c > 0) m_c--; end
            else if (e[0]) begin if (m_c < 4) m_c++; end
         end
         2: begin
            if (m_fits()) begin
               m_tab = m_tab | m_mask();
               m_n++;
               m_f = 0; m_c = 0; m_o = 0;
               if (m_n == m_cnt) begin
                  m_st = 3;
                  m_lista = 1;
               end else m_st = 1;
            end else m_st = 1;
         end
         default: ;
      endcase
   endtask

   // Drive one cycle of stimulus, push the prediction, compare after the edge
   task automatic step(input logic [5:0] b, input string tag);
      {btnColocar, btnRotar, btnArriba, btnAbajo, btnIzquierda, btnDerecha} = b;
      seleccionListo = g_sel;
      cantidadBarcosSeleccionada = g_cnt;
      model_clock(b);
      exp_q.push_back(m_snap());
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      check_val(tag_q.pop_front(), dut_snap(), exp_q.pop_front());
   endtask

   task automatic press(input logic [5:0] b, input string tag);
      step(b, tag);
      step(B_NONE, {tag, "_rel"});
   endtask

   task automatic apply_reset(input string tag);
      reset = 1'b0;
      {btnColocar, btnRotar, btnArriba, btnAbajo, btnIzquierda, btnDerecha} = B_NONE;
      g_sel = 1'b0;
      g_cnt = 3'd0;
      seleccionListo = 1'b0;
      cantidadBarcosSeleccionada = 3'd0;
      #1;
      check_val(tag, dut_snap(), 64'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      model_reset();
      apply_reset("rst_init");

      // Two ships: 1 at (0,0), then 2 at (0,2) completes the board
      g_sel = 1'b1; g_cnt = 3'd2;
      step(B_NONE, "a_sel");
      press(B_COL, "a_col1");
      check_val("a_tab1", 64'(tablero), 64'h1);
      press(B_DER, "a_der1");
      press(B_DER, "a_der2");
      check_val("a_col_pos", 64'(columna), 64'd2);
      press(B_COL, "a_col2");
      check_val("a_tab2", 64'(tablero), 64'hD);
      check_val("a_lista", 64'(colocacionLista), 64'd1);
      press(B_DER, "a_listo_der");
      check_val("a_listo_colpos", 64'(columna), 64'd0);

      // Ship 3 horizontal at columna 3 runs off the board
      apply_reset("rst_b");
      g_sel = 1'b1; g_cnt = 3'd3;
      step(B_NONE, "b_sel");
      press(B_COL, "b_col1");
      press(B_ABA, "b_aba");
      press(B_COL, "b_col2");
      check_val("b_tab2", 64'(tablero), 64'h61);
      press(B_DER, "b_der1");
      press(B_DER, "b_der2");
      press(B_DER, "b_der3");
      step(B_COL, "b_col3");
      check_val("b_err_hi", 64'(errorColocacion), 64'd1);
      step(B_NONE, "b_col3_rel");
      check_val("b_err_lo", 64'(errorColocacion), 64'd0);
      check_val("b_tab_keep", 64'(tablero), 64'h61);
      check_val("b_cnt_keep", 64'(barcosColocados), 64'd2);
      press(B_DER, "b_der4");
      check_val("b_still_placing", 64'(columna), 64'd4);

      // Ship 2 vertical at (0,0) overlaps ship 1
      apply_reset("rst_c");
      g_sel = 1'b1; g_cnt = 3'd2;
      step(B_NONE, "c_sel");
      press(B_COL, "c_col1");
      press(B_ROT, "c_rot");
      check_val("c_orient", 64'(orientacion), 64'd1);
      step(B_COL, "c_col2");
      check_val("c_err_hi", 64'(errorColocacion), 64'd1);
      step(B_NONE, "c_col2_rel");
      check_val("c_cnt_keep", 64'(barcosColocados), 64'd1);

      // Held abajo moves once; repeated pulses saturate at the bottom row
      apply_reset("rst_d");
      g_sel = 1'b1; g_cnt = 3'd5;
      step(B_NONE, "d_sel");
      for (int i = 0; i < 10; i++) step(B_ABA, "d_hold");
      check_val("d_hold_fila", 64'(fila), 64'd1);
      step(B_NONE, "d_hold_rel");
      for (int i = 0; i < 6; i++) press(B_ABA, "d_pulse");
      check_val("d_sat_fila", 64'(fila), 64'd4);

      // colocar wins over derecha in the same cycle
      step(B_COL | B_DER, "e_colder");
      step(B_NONE, "e_colder_rel");
      check_val("e_tab", 64'(tablero), 64'h100000);
      check_val("e_columna", 64'(columna), 64'd0);

      // Reset while validating discards the in-flight ship
      apply_reset("rst_f0");
      g_sel = 1'b1; g_cnt = 3'd3;
      step(B_NONE, "f_sel");
      press(B_COL, "f_col1");
      press(B_DER, "f_der");
      step(B_COL, "f_col2");
      apply_reset("rst_f_mid");
      g_sel = 1'b1; g_cnt = 3'd0;
      step(B_NONE, "f_cnt0");
      press(B_DER, "f_cnt0_der");
      press(B_COL, "f_cnt0_col");
      check_val("f_espera_col", 64'(columna), 64'd0);
      check_val("f_espera_tab", 64'(tablero), 64'd0);
      g_cnt = 3'd3;
      step(B_NONE, "f_sel3");
      press(B_DER, "f_der2");
      check_val("f_restart_col", 64'(columna), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/colocar_barcos.md
COLOCAR_BARCOS -- requirements
Module: colocar_barcos

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low; 0 clears all state immediately.
REQ-003 SHALL have ports: cantidadBarcosSeleccionada  in  3  ship count from the selection stage.
REQ-004 SHALL have ports: seleccionListo  in  1  level, selection stage has a valid count.
REQ-005 SHALL have ports: btnArriba, btnAbajo, btnIzquierda, btnDerecha, btnRotar, btnColocar  in  1 each  debounced level buttons.
REQ-006 SHALL have ports: tablero  out  25  placed-ship bitmap, bit = fila*5+columna.
REQ-007 SHALL have ports: fila, columna  out  3 each  cursor position, 0..4.
REQ-008 SHALL have ports: orientacion  out  1  0 = horizontal (+columna), 1 = vertical (+fila).
REQ-009 SHALL have ports: barcosColocados  out  3  ships placed so far.
REQ-010 SHALL have ports: colocacionLista  out  1  all ships placed; level.
REQ-011 SHALL have ports: errorColocacion  out  1  one-cycle pulse on rejected placement.
REQ-012 SHALL have ports: vista  out  25  display bitmap (see Configuration).

Function
REQ-013 SHALL implement FSM states ESPERA, COLOCANDO, VALIDAR, LISTO.
REQ-014 SHALL act on a button only on its rising edge, i.e. current sample 1 and the previous-cycle registered sample 0; a held button acts once.
REQ-015 SHALL, in ESPERA, latch cantidadBarcosSeleccionada and go to COLOCANDO when seleccionListo=1 and the count is 1..5; other counts keep ESPERA.
REQ-016 SHALL set current ship length = barcosColocados+1 (ship k has length k).
REQ-017 SHALL, in COLOCANDO, act on at most one edge per cycle with priority colocar > rotar > arriba > abajo > izquierda > derecha; lower-priority edges in the same cycle are dropped.
REQ-018 SHALL saturate cursor moves at 0 and 4 (no wrap-around).
REQ-019 SHALL toggle orientacion on a rotar edge without moving the cursor.
REQ-020 SHALL, on a colocar edge, go to VALIDAR the next cycle.
REQ-021 SHALL accept a placement when the ship fits in bounds (horizontal: columna+len<=5; vertical: fila+len<=5) and its mask has no overlap with tablero.
REQ-022 SHALL, on accept in VALIDAR, update tablero |= mask and barcosColocados+1, reset the cursor to (0,0) horizontal, and go to LISTO if the new count equals the latched count, else COLOCANDO; all in one cycle.
REQ-023 SHALL, on reject in VALIDAR, pulse errorColocacion for exactly that cycle, leave tablero/cursor unchanged, and return to COLOCANDO.
REQ-024 SHALL, in LISTO, hold colocacionLista=1 and ignore all buttons and upstream inputs until reset.
REQ-025 SHALL ignore buttons in ESPERA and VALIDAR; edge history still updates.

Reset
REQ-026 SHALL, on reset=0, immediately force ESPERA, tablero=0, fila=0, columna=0, orientacion=0, barcosColocados=0, colocacionLista=0, errorColocacion=0, button history=0, latched count=0.
REQ-027 SHALL discard any in-progress placement when reset is asserted mid-operation; the block restarts from ESPERA after release.

Configuration
REQ-028 SHALL, with VISTA_PREVIA_EN defined, drive vista = tablero | mask of the current ship at the cursor (in-bounds cells only) while in COLOCANDO, and vista = tablero in all other states.
REQ-029 SHALL, with VISTA_PREVIA_EN undefined, drive vista = tablero always and contain no preview logic.

Verification
REQ-030 SHALL cover: count 2, seleccionListo=1; colocar at (0,0) horizontal -> tablero=0x0000001; then derecha x2, colocar -> tablero=0x000000D, colocacionLista=1.
REQ-031 SHALL cover: ship 3 horizontal at columna 3 -> errorColocacion pulses 1 cycle, tablero unchanged, still COLOCANDO.
REQ-032 SHALL cover: overlap case, ship 2 vertical at (0,0) over ship 1 at (0,0) -> errorColocacion, barcosColocados stays 1.
REQ-033 SHALL cover: abajo held 10 cycles -> fila=1; then 6 separate abajo pulses -> fila saturates at 4.
REQ-034 SHALL cover: colocar and derecha in the same cycle -> placement attempted, columna unchanged.
REQ-035 SHALL cover: reset pulsed low during VALIDAR with 1 ship placed -> all outputs at reset values; count 0 with seleccionListo=1 stays in ESPERA.
